// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-pc select codes,
// sequencer state encoding and the default address width.
package pc_sequencer_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;

  localparam int SEL_WIDTH = 3;
  localparam logic [SEL_WIDTH-1:0] SEL_HOLD   = 3'd0;
  localparam logic [SEL_WIDTH-1:0] SEL_INC    = 3'd1;
  localparam logic [SEL_WIDTH-1:0] SEL_BRANCH = 3'd2;
  localparam logic [SEL_WIDTH-1:0] SEL_JUMP   = 3'd3;
  localparam logic [SEL_WIDTH-1:0] SEL_CALL   = 3'd4;
  localparam logic [SEL_WIDTH-1:0] SEL_RET    = 3'd5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return-address LIFO: register array indexed by an occupancy count.
// Push and pop are mutually exclusive; the parent guarantees it.
module pc_sequencer_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr, top_ptr;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign depth   = count_reg;
  // When full the low count bits wrap to 0, so top_ptr still lands on DEPTH-1.
  assign wr_ptr  = count_reg[PTR_W-1:0];
  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top_data = mem_reg[top_ptr];

  always_comb begin
    count_next = count_reg;
    if (push && !full) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Contents need no reset; only the count defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_reg[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding the instruction memory address bus, with
// stall, relative branch, absolute jump, call/return and sticky halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int                    OFFSET_WIDTH = 6,
  parameter int                    STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          branch_taken,
  input  logic [OFFSET_WIDTH-1:0]       branch_offset,
  input  logic                          jump,
  input  logic                          call,
  input  logic                          ret,
  input  logic [ADDR_WIDTH-1:0]         target,
  input  logic                          halt,
  output logic [ADDR_WIDTH-1:0]         pc,
  output logic                          halted,
  output logic                          stack_overflow,
  output logic                          stack_underflow,
  output logic [$clog2(STACK_DEPTH):0]  stack_depth
);

  seq_state_e            state_reg, state_next;
  logic [SEL_WIDTH-1:0]  sel;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next, pc_inc, pc_branch, stack_top;
  logic                  overflow_reg, underflow_reg;
  logic                  overflow_set, underflow_set;
  logic                  push, pop, stack_full, stack_empty;

  assign pc_inc    = pc_reg + ADDR_WIDTH'(1);
  assign pc_branch = pc_reg + {{(ADDR_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}},
                               branch_offset};

  pc_sequencer_return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .depth     (stack_depth)
  );

  // Strict priority: halt > ret > call > jump > branch > increment.
  always_comb begin
    sel           = SEL_HOLD;
    state_next    = state_reg;
    push          = 1'b0;
    pop           = 1'b0;
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
    if (state_reg == ST_RUN && enable) begin
      if (halt) begin
        state_next = ST_HALT;
      end else if (ret) begin
        if (stack_empty) begin
          underflow_set = 1'b1;
          state_next    = ST_HALT;
        end else begin
          sel = SEL_RET;
          pop = 1'b1;
        end
      end else if (call) begin
        if (stack_full) begin
          overflow_set = 1'b1;
          state_next   = ST_HALT;
        end else begin
          sel  = SEL_CALL;
          push = 1'b1;
        end
      end else if (jump) begin
        sel = SEL_JUMP;
      end else if (branch_taken) begin
        sel = SEL_BRANCH;
      end else begin
        sel = SEL_INC;
      end
    end
  end

  always_comb begin
    pc_next = pc_reg;
    case (sel)
      SEL_INC:             pc_next = pc_inc;
      SEL_BRANCH:          pc_next = pc_branch;
      SEL_JUMP, SEL_CALL:  pc_next = target;
      SEL_RET:             pc_next = stack_top;
      default:             pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      pc_reg        <= RESET_VECTOR;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      overflow_reg  <= overflow_reg | overflow_set;
      underflow_reg <= underflow_reg | underflow_set;
    end
  end

  assign pc              = pc_reg;
  assign halted          = (state_reg == ST_HALT);
  assign stack_overflow  = overflow_reg;
  assign stack_underflow = underflow_reg;

endmodule
